// File: rtl/soc_framebuffer_dbuf_if.sv
// ---------------------------------------------------------------------------
// soc_framebuffer_dbuf_if
// Bundles the CPU request/ack port and the scanout port of the
// double-buffered framebuffer.
//
// Handshake semantics:
//   CPU: cpu_req is sampled on every clock edge, and there is no ready signal.
//        The access completes with a one-cycle cpu_ack pulse exactly one cycle
//        later. cpu_rdata/cpu_err are meaningful only while cpu_ack is high.
//   Scan: each cycle with scan_valid high issues one fetch. scan_pixel_valid
//        marks the matching result exactly two cycles later. There is no
//        back-pressure.
//
// Modports: master = requester (CPU / VGA side), slave = framebuffer.
// ---------------------------------------------------------------------------
interface soc_framebuffer_dbuf_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int IDX_WIDTH  = 19,
  parameter int BPP        = 8
);
  logic                  cpu_req;
  logic [3:0]            cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ack;
  logic                  cpu_err;
  logic                  scan_valid;
  logic [IDX_WIDTH-1:0]  scan_index;
  logic [BPP-1:0]        scan_pixel;
  logic                  scan_pixel_valid;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, scan_valid, scan_index,
    input  cpu_rdata, cpu_ack, cpu_err, scan_pixel, scan_pixel_valid
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, scan_valid, scan_index,
    output cpu_rdata, cpu_ack, cpu_err, scan_pixel, scan_pixel_valid
  );
endinterface

// File: rtl/soc_framebuffer_dbuf.sv
// ---------------------------------------------------------------------------
// soc_framebuffer_dbuf
// Single-clock, double-buffered framebuffer. The CPU reads and writes the back
// page. Scanout fetches packed pixels from the front page with a latency of
// 2 cycles. A flip requested by software is committed only on frame_start.
//
// Ports:
//   clk, res       clock and asynchronous active-high reset
//   bus            CPU request/ack port and scanout port (slave modport)
//   flip_req       pulse that requests a page swap
//   frame_start    pulse on the first cycle of a frame (flip commit point)
//   front_page     page currently scanned out
//   flip_pending   a swap has been requested but is not yet committed
//   dbg_state      raw flip FSM state (0 = IDLE, 1 = PENDING)
// ---------------------------------------------------------------------------
module soc_framebuffer_dbuf #(
  parameter int BPP        = 8,
  parameter int PIXELS     = 307200,
  parameter int ADDR_WIDTH = 20,
  parameter int IDX_WIDTH  = 19
) (
  input  logic                   clk,
  input  logic                   res,
  soc_framebuffer_dbuf_if.slave  bus,
  input  logic                   flip_req,
  input  logic                   frame_start,
  output logic                   front_page,
  output logic                   flip_pending,
  output logic                   dbg_state
);
  localparam int PPW   = 32 / BPP;
  localparam int WORDS = PIXELS * BPP / 32;
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LW    = $clog2(PPW);
  localparam int PA_W  = WW + 1;
  // The physical word is {page, word}. Page 1 starts at 2^WW, so the array
  // only needs to extend to the last word of page 1.
  localparam int DEPTH = (2 ** WW) + WORDS;

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} flip_state_t;

  flip_state_t state_q, state_d;
  logic        front_page_q, front_page_d;

  logic [31:0] mem [DEPTH];

  // CPU request decode. This logic is combinational and belongs to the
  // request cycle.
  logic [ADDR_WIDTH-3:0] cpu_word;
  logic                  cpu_oob, cpu_rd, cpu_wr;
  logic [PA_W-1:0]       cpu_pa;

  logic cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
  logic [31:0] cpu_rdata_q;

  // Scan stage 0 (request registered) and stage 1 (RAM output registered)
  logic            scan_v0_q, scan_v0_d, scan_oob0_q, scan_oob0_d;
  logic [LW-1:0]   scan_lane0_q, scan_lane0_d;
  logic [PA_W-1:0] scan_pa0_q, scan_pa0_d;
  logic            scan_v1_q, scan_v1_d, scan_oob1_q, scan_oob1_d;
  logic [LW-1:0]   scan_lane1_q, scan_lane1_d;
  logic [31:0]     scan_ram_q;
  logic            scan_oob_req;

  always_comb begin
    cpu_word = bus.cpu_addr[ADDR_WIDTH-1:2];
    cpu_oob  = 32'(cpu_word) >= 32'(WORDS);
    cpu_pa   = {~front_page_q, cpu_word[WW-1:0]};
    cpu_rd   = bus.cpu_req && (bus.cpu_we == 4'b0000);
    cpu_wr   = bus.cpu_req && (bus.cpu_we != 4'b0000) && !cpu_oob;
  end

  // Flip FSM. On commit, front_page toggles and the FSM returns to IDLE in
  // the same cycle. A flip_req that arrives while PENDING has no effect.
  always_comb begin
    state_d      = state_q;
    front_page_d = front_page_q;
    case (state_q)
      ST_IDLE:    if (flip_req) state_d = ST_PENDING;
      ST_PENDING: if (frame_start) begin
        state_d      = ST_IDLE;
        front_page_d = ~front_page_q;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_ack_d    = bus.cpu_req;
    cpu_err_d    = bus.cpu_req && cpu_oob;
    scan_oob_req = 32'(bus.scan_index) >= 32'(PIXELS);
    scan_v0_d    = bus.scan_valid;
    scan_oob0_d  = scan_oob_req;
    scan_lane0_d = bus.scan_index[LW-1:0];
    // For an out-of-range index, fetch word 0 so the RAM address stays legal.
    // The pixel is forced to 0 later in the pipeline.
    scan_pa0_d   = {front_page_q, scan_oob_req ? WW'(0) : bus.scan_index[LW +: WW]};
    scan_v1_d    = scan_v0_q;
    scan_oob1_d  = scan_oob1_q;
    scan_lane1_d = scan_lane1_q;
    if (scan_v0_q) begin
      scan_oob1_d  = scan_oob0_q;
      scan_lane1_d = scan_lane0_q;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= ST_IDLE;
      front_page_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      scan_v0_q    <= 1'b0;
      scan_oob0_q  <= 1'b0;
      scan_lane0_q <= '0;
      scan_pa0_q   <= '0;
      scan_v1_q    <= 1'b0;
      scan_oob1_q  <= 1'b0;
      scan_lane1_q <= '0;
    end else begin
      state_q      <= state_d;
      front_page_q <= front_page_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_err_q    <= cpu_err_d;
      scan_v0_q    <= scan_v0_d;
      scan_oob0_q  <= scan_oob0_d;
      scan_lane0_q <= scan_lane0_d;
      scan_pa0_q   <= scan_pa0_d;
      scan_v1_q    <= scan_v1_d;
      scan_oob1_q  <= scan_oob1_d;
      scan_lane1_q <= scan_lane1_d;
    end
  end

  // RAM write port. The RAM contents are not reset.
  always_ff @(posedge clk) begin
    if (cpu_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_we[b]) mem[cpu_pa][b*8 +: 8] <= bus.cpu_wdata[b*8 +: 8];
      end
    end
  end

  // RAM output registers. The reads are read-first: a write and a read of the
  // same word on the same edge return the old data. cpu_rdata and scan_ram
  // update only when they capture a new result, so both hold between
  // accesses.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cpu_rdata_q <= '0;
      scan_ram_q  <= '0;
    end else begin
      if (cpu_rd)    cpu_rdata_q <= cpu_oob ? 32'h0 : mem[cpu_pa];
      if (scan_v0_q) scan_ram_q  <= mem[scan_pa0_q];
    end
  end

  assign bus.cpu_ack          = cpu_ack_q;
  assign bus.cpu_err          = cpu_err_q;
  assign bus.cpu_rdata        = cpu_rdata_q;
  assign bus.scan_pixel_valid = scan_v1_q;
  assign bus.scan_pixel       = scan_oob1_q ? '0 : scan_ram_q[scan_lane1_q*BPP +: BPP];
  assign front_page           = front_page_q;
  assign flip_pending         = (state_q == ST_PENDING);
  assign dbg_state            = state_q;
endmodule

// File: tb/tb_soc_framebuffer_dbuf.sv
module tb_soc_framebuffer_dbuf;
  localparam int BPP = 4;
  localparam int PIXELS = 64;
  localparam int AW = 8;
  localparam int IW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic flip_req, frame_start, front_page, flip_pending, dbg_state;

  soc_framebuffer_dbuf_if #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .BPP(BPP)) bus ();

  soc_framebuffer_dbuf #(.BPP(BPP), .PIXELS(PIXELS), .ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .res          (res),
    .bus          (bus),
    .flip_req     (flip_req),
    .frame_start  (frame_start),
    .front_page   (front_page),
    .flip_pending (flip_pending),
    .dbg_state    (dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard queues ----------------
  logic [31:0]    cpu_exp_q[$];
  logic           cpu_err_q[$];
  logic           cpu_isrd_q[$];
  int             cpu_cyc_q[$];
  logic [BPP-1:0] scan_exp_q[$];
  int             scan_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // tick: advance one clock, then clear all request inputs. Requests that are
  // set after a tick are sampled on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.scan_valid = 1'b0; bus.scan_index = '0;
    flip_req = 1'b0; frame_start = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] we, input logic [AW-1:0] addr,
                           input logic [31:0] d, input logic err);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = d;
    cpu_exp_q.push_back(32'h0); cpu_err_q.push_back(err);
    cpu_isrd_q.push_back(1'b0); cpu_cyc_q.push_back(cyc + 1);
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr, input logic [31:0] exp, input logic err);
    bus.cpu_req = 1'b1; bus.cpu_we = 4'h0; bus.cpu_addr = addr; bus.cpu_wdata = '0;
    cpu_exp_q.push_back(exp); cpu_err_q.push_back(err);
    cpu_isrd_q.push_back(1'b1); cpu_cyc_q.push_back(cyc + 1);
  endtask

  task automatic scan(input logic [IW-1:0] idx, input logic [BPP-1:0] exp);
    bus.scan_valid = 1'b1; bus.scan_index = idx;
    scan_exp_q.push_back(exp); scan_cyc_q.push_back(cyc + 2);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!res) begin
      if (bus.cpu_ack) begin
        if (cpu_cyc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cpu_ack_unexpected: got ack=1 expected no ack (cycle %0d)", cyc);
        end else begin
          check("cpu_ack_cycle", cyc, cpu_cyc_q.pop_front());
          check("cpu_err", bus.cpu_err, cpu_err_q.pop_front());
          if (cpu_isrd_q.pop_front()) check("cpu_rdata", bus.cpu_rdata, cpu_exp_q.pop_front());
          else void'(cpu_exp_q.pop_front());
        end
      end else if (cpu_cyc_q.size() != 0 && cpu_cyc_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL cpu_ack_missing: got ack=0 expected ack=1 (cycle %0d)", cyc);
        void'(cpu_cyc_q.pop_front()); void'(cpu_err_q.pop_front());
        void'(cpu_isrd_q.pop_front()); void'(cpu_exp_q.pop_front());
      end
      if (bus.scan_pixel_valid) begin
        if (scan_cyc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scan_valid_unexpected: got valid=1 expected valid=0 (cycle %0d)", cyc);
        end else begin
          check("scan_cycle", cyc, scan_cyc_q.pop_front());
          check("scan_pixel", 32'(bus.scan_pixel), 32'(scan_exp_q.pop_front()));
        end
      end else if (scan_cyc_q.size() != 0 && scan_cyc_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL scan_valid_missing: got valid=0 expected valid=1 (cycle %0d)", cyc);
        void'(scan_cyc_q.pop_front()); void'(scan_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    res = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 4'h0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.scan_valid = 1'b0; bus.scan_index = '0;
    flip_req = 1'b0; frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;

    // 1. reset state after 3 idle cycles
    repeat (3) tick();
    check("reset_front_page", front_page, 0);
    check("reset_flip_pending", flip_pending, 0);
    check("reset_cpu_ack", bus.cpu_ack, 0);
    check("reset_scan_valid", bus.scan_pixel_valid, 0);
    check("reset_cpu_rdata", bus.cpu_rdata, 0);

    // 2. write and read back page 1, word 0
    cpu_write(4'hF, 8'h00, 32'h76543210, 1'b0); tick();
    cpu_read(8'h00, 32'h76543210, 1'b0); tick();

    // 3. flip after 5 idle cycles, then scan pixels 0..7
    flip_req = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      check("pend_wait_flip_pending", flip_pending, 1);
      check("pend_wait_front_page", front_page, 0);
      tick();
    end
    frame_start = 1'b1;
    check("commit_cycle_flip_pending", flip_pending, 1);
    tick();
    check("after_commit_front_page", front_page, 1);
    check("after_commit_flip_pending", flip_pending, 0);
    for (int i = 0; i < 8; i++) begin
      scan(IW'(i), BPP'(i));
      tick();
    end
    // The back page is now page 0.
    cpu_write(4'hF, 8'h00, 32'hFEDCBA98, 1'b0); tick();
    cpu_read(8'h00, 32'hFEDCBA98, 1'b0); tick();

    // 4. flip_req together with frame_start in IDLE: pend only
    flip_req = 1'b1; frame_start = 1'b1; tick();
    check("same_cycle_flip_pending", flip_pending, 1);
    check("same_cycle_front_page", front_page, 1);
    flip_req = 1'b1; tick();   // ignored while pending
    check("repeat_req_flip_pending", flip_pending, 1);
    // The commit cycle still uses the pre-toggle page on both ports.
    frame_start = 1'b1;
    scan(IW'(0), BPP'(0));                     // page 1 word 0, lane 0
    cpu_read(8'h00, 32'hFEDCBA98, 1'b0);       // back page 0
    tick();
    check("second_commit_front_page", front_page, 0);
    check("second_commit_flip_pending", flip_pending, 0);
    scan(IW'(1), BPP'(9));                     // page 0 word 0, lane 1
    tick();

    // 5. out-of-range accesses and a byte-masked write on back page 1
    cpu_write(4'hF, 8'h20, 32'hFFFFFFFF, 1'b1); tick();
    cpu_read(8'h20, 32'h0, 1'b1); tick();
    cpu_read(8'h00, 32'h76543210, 1'b0);       // a suppressed write must not alias word 0
    scan(IW'(64), BPP'(0));
    tick();
    cpu_write(4'hF, 8'h04, 32'h33221100, 1'b0); tick();
    cpu_write(4'h2, 8'h04, 32'h0000AB00, 1'b0); tick();
    cpu_read(8'h04, 32'h3322AB00, 1'b0); tick();
    cpu_write(4'hF, 8'h08, 32'h12345678, 1'b0); tick();
    tick();
    check("rdata_hold_after_write", bus.cpu_rdata, 32'h3322AB00);

    // 6. reset during a scan burst with a flip pending
    flip_req = 1'b1; tick();
    frame_start = 1'b1; tick();
    check("pre_reset_front_page", front_page, 1);
    flip_req = 1'b1; tick();
    scan(IW'(0), BPP'(0)); tick();
    scan(IW'(1), BPP'(1)); tick();
    scan(IW'(2), BPP'(2)); tick();
    check("burst_scan_valid", bus.scan_pixel_valid, 1);
    check("burst_flip_pending", flip_pending, 1);
    res = 1'b1;
    #1;
    check("async_reset_scan_valid", bus.scan_pixel_valid, 0);
    check("async_reset_front_page", front_page, 0);
    check("async_reset_flip_pending", flip_pending, 0);
    scan_exp_q.delete(); scan_cyc_q.delete();
    @(posedge clk);
    #1 res = 1'b0;
    repeat (4) tick();
    check("post_reset_scan_valid", bus.scan_pixel_valid, 0);
    check("post_reset_front_page", front_page, 0);

    repeat (3) tick();
    check("cpu_queue_drained", cpu_cyc_q.size(), 0);
    check("scan_queue_drained", scan_cyc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
